mtr_incr_sched: RTL and testbench

Scheduler for the meter counter bank (TIME, PERF, EBOX, CACHE). Each hardware counter is CNT_W bits wide and raises a half-full request. The block picks one pending counter, reads it through the meter read mux, adds the value into a wide per-counter software accumulator, clears the hardware counter, and waits for the request to drop. It replaces the microcode read/add/clear loop and also gives the EBOX a read/clear port onto the accumulators.

---
 rtl/mtr_incr_sched_if.sv | 32 +++
 rtl/mtr_incr_sched.sv | 171 +++++++++++++++++
 tb/tb_mtr_incr_sched.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtr_incr_sched_if.sv
// Meter scheduler bus: counter request levels, meter read mux handshake,
// counter clear strobes and the EBOX accumulator read/clear port.
//   master : scheduler side (drives rd_en/rd_sel/clr/acc_rd/busy/cur_sel/err)
//   slave  : environment side (drives ovf_req/rd_valid/rd_data/acc_rd_idx/acc_clr/err_clr)
interface mtr_incr_sched_if #(
    parameter int unsigned CNT_W = 17,
    parameter int unsigned ACC_W = 36
);
    logic [3:0]       ovf_req;
    logic             rd_en;
    logic [1:0]       rd_sel;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic [3:0]       clr;
    logic [1:0]       acc_rd_idx;
    logic [ACC_W-1:0] acc_rd;
    logic             acc_clr;
    logic             busy;
    logic [1:0]       cur_sel;
    logic             err;
    logic             err_clr;

    modport master (
        input  ovf_req, rd_valid, rd_data, acc_rd_idx, acc_clr, err_clr,
        output rd_en, rd_sel, clr, acc_rd, busy, cur_sel, err
    );

    modport slave (
        output ovf_req, rd_valid, rd_data, acc_rd_idx, acc_clr, err_clr,
        input  rd_en, rd_sel, clr, acc_rd, busy, cur_sel, err
    );
endinterface

// File: rtl/mtr_incr_sched.sv
// Meter counter increment scheduler. Picks a pending half-full counter
// (TIME, PERF, EBOX, CACHE), reads it through the meter mux, adds it into a
// wide per-counter accumulator, pulses the counter clear and waits for the
// request to drop. Also exposes an accumulator read/clear port.
// Ports:
//   clk    : block clock
//   RESET  : synchronous active-high reset
//   bus    : mtr_incr_sched_if.master (ovf_req, rd_en/rd_sel/rd_valid/rd_data,
//            clr, acc_rd_idx/acc_rd/acc_clr, busy, cur_sel, err/err_clr)
// Build option: define MTR_SCHED_RR_EN for round-robin arbitration instead of
// fixed priority TIME > PERF > EBOX > CACHE.
module mtr_incr_sched #(
    parameter int unsigned CNT_W   = 17,
    parameter int unsigned ACC_W   = 36,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             RESET,
    mtr_incr_sched_if.master bus
);
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADD,
        S_CLR,
        S_DRAIN
    } state_t;

    state_t                 state;
    logic [1:0]             sel;
    logic [CNT_W-1:0]       cap;
    logic [TCNT_W-1:0]      tcnt;
    logic                   rd_en;
    logic [3:0]             clr;
    logic                   busy;
    logic                   err;
    logic [ACC_W-1:0]       acc_rd;
    logic [3:0][ACC_W-1:0]  acc_q;
    logic [3:0][ACC_W-1:0]  acc_nxt_c;
    logic                   req_any_c;
    logic [1:0]             grant_c;

    // Arbiter: lowest search offset with a pending request wins.
`ifdef MTR_SCHED_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] idx_c;

    always_comb begin
        req_any_c = |bus.ovf_req;
        grant_c   = 2'd0;
        idx_c     = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx_c = rr_ptr + 2'(i);
            if (bus.ovf_req[idx_c]) grant_c = idx_c;
        end
    end
`else
    always_comb begin
        req_any_c = |bus.ovf_req;
        grant_c   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.ovf_req[2'(i)]) grant_c = 2'(i);
        end
    end
`endif

    // Service sequencer with timeout on the WAIT and DRAIN phases.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state <= S_IDLE;
            sel   <= 2'd0;
            cap   <= '0;
            tcnt  <= '0;
            rd_en <= 1'b0;
            clr   <= 4'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
`ifdef MTR_SCHED_RR_EN
            rr_ptr <= 2'd0;
`endif
        end else begin
            clr <= 4'b0;
            // Written before the timeout branches so a same-cycle set wins.
            if (bus.err_clr) err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_any_c) begin
                        state <= S_WAIT;
                        sel   <= grant_c;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                        tcnt  <= '0;
`ifdef MTR_SCHED_RR_EN
                        rr_ptr <= grant_c + 2'd1;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.rd_valid) begin
                        cap   <= bus.rd_data;
                        rd_en <= 1'b0;
                        state <= S_ADD;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        rd_en <= 1'b0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_ADD: begin
                    clr   <= 4'b0001 << sel;
                    state <= S_CLR;
                end
                S_CLR: begin
                    tcnt  <= '0;
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.ovf_req[sel]) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                default: begin
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Accumulator next value: external clear applies first, then the add.
    always_comb begin
        acc_nxt_c = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (bus.acc_clr && (bus.acc_rd_idx == 2'(i))) acc_nxt_c[i] = '0;
            if ((state == S_ADD) && (sel == 2'(i)))
                acc_nxt_c[i] = acc_nxt_c[i] + ACC_W'(cap);
        end
    end

    // Accumulator bank and post-update read port.
    always_ff @(posedge clk) begin
        if (RESET) begin
            acc_q  <= '0;
            acc_rd <= '0;
        end else begin
            acc_q  <= acc_nxt_c;
            acc_rd <= acc_nxt_c[bus.acc_rd_idx];
        end
    end

    assign bus.rd_en   = rd_en;
    assign bus.rd_sel  = sel;
    assign bus.cur_sel = sel;
    assign bus.clr     = clr;
    assign bus.busy    = busy;
    assign bus.err     = err;
    assign bus.acc_rd  = acc_rd;
endmodule

// File: tb/tb_mtr_incr_sched.sv
// Bench for mtr_incr_sched: scenario tasks with randomized traffic checked
// against a transaction-level model of arbitration and accumulation.
module tb_mtr_incr_sched;
`ifdef MTR_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk;
    logic RESET;

    mtr_incr_sched_if #(.CNT_W(17), .ACC_W(36)) bus ();
    mtr_incr_sched_if #(.CNT_W(17), .ACC_W(18)) bus_w ();

    mtr_incr_sched #(.CNT_W(17), .ACC_W(36), .TIMEOUT(64)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    // Narrow-accumulator instance so wrap-around is reachable in few services.
    mtr_incr_sched #(.CNT_W(17), .ACC_W(18), .TIMEOUT(64)) dut_w (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  req;
    logic [35:0] acc_m [4];
    int          rr_m;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next index to serve: first pending request in search order from ptr.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (r[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return 0;
    endfunction

    // One complete service of index exp, DUT idle on entry with req set.
    task automatic run_service(input int exp, input logic [16:0] val, input int dly,
                               input logic [3:0] raise, input bit clr_in_add);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << exp;
        n = 0;
        while (bus.rd_en !== 1'b1 && n < 8) begin tick(); n++; end
        checks++;
        if (bus.rd_en !== 1'b1) begin
            errors++;
            $display("FAIL svc_rd_en: rd_en=%b expected 1", bus.rd_en);
            return;
        end
        checks++;
        if (bus.rd_sel !== 2'(exp)) begin
            errors++;
            $display("FAIL svc_rd_sel: rd_sel=%0d expected %0d", bus.rd_sel, exp);
        end
        rr_m = (exp + 1) % 4;
        req = req | (raise & ~oh);
        bus.ovf_req = req;
        for (int i = 0; i < dly; i++) tick();
        bus.rd_valid = 1'b1;
        bus.rd_data  = val;
        tick();
        bus.rd_valid = 1'b0;
        bus.rd_data  = 17'($urandom);
        if (clr_in_add) begin
            bus.acc_clr    = 1'b1;
            bus.acc_rd_idx = 2'(exp);
            acc_m[exp]     = '0;
        end
        acc_m[exp] = acc_m[exp] + 36'(val);
        tick();
        bus.acc_clr = 1'b0;
        checks++;
        if (bus.clr !== oh) begin
            errors++;
            $display("FAIL svc_clr: clr=%b expected %b", bus.clr, oh);
        end
        req[exp] = 1'b0;
        bus.ovf_req = req;
        tick();
        checks++;
        if (bus.clr !== 4'b0) begin
            errors++;
            $display("FAIL svc_clr_pulse: clr=%b expected 0000", bus.clr);
        end
        n = 0;
        while (bus.busy !== 1'b0 && n < 4) begin tick(); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL svc_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.rd_en, bus.rd_sel, bus.clr, bus.busy, bus.cur_sel, bus.err} !== 11'b0 ||
            bus.acc_rd !== 36'b0) begin
            errors++;
            $display("FAIL reset_outputs: rd_en=%b rd_sel=%0d clr=%b busy=%b cur_sel=%0d err=%b acc_rd=%h expected all 0",
                     bus.rd_en, bus.rd_sel, bus.clr, bus.busy, bus.cur_sel, bus.err, bus.acc_rd);
        end
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) acc_m[k] = '0;
        rr_m = 0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0010;
        bus.ovf_req = req;
        bus.acc_rd_idx = 2'd1;
        tick();
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_sel !== 2'd1 || bus.busy !== 1'b1 || bus.cur_sel !== 2'd1) begin
            errors++;
            $display("FAIL single_grant: rd_en=%b rd_sel=%0d busy=%b cur_sel=%0d expected 1 1 1 1",
                     bus.rd_en, bus.rd_sel, bus.busy, bus.cur_sel);
        end
        tick();
        bus.rd_valid = 1'b1;
        bus.rd_data  = 17'h10000;
        tick();
        bus.rd_valid = 1'b0;
        checks++;
        if (bus.rd_en !== 1'b0 || bus.clr !== 4'b0) begin
            errors++;
            $display("FAIL single_add: rd_en=%b clr=%b expected 0 0000", bus.rd_en, bus.clr);
        end
        tick();
        checks++;
        if (bus.clr !== 4'b0010) begin
            errors++;
            $display("FAIL single_clr_latency: clr=%b expected 0010", bus.clr);
        end
        req = 4'b0;
        bus.ovf_req = req;
        tick();
        acc_m[1] = 36'h10000;
        rr_m = 2;
        checks++;
        if (bus.clr !== 4'b0 || bus.busy !== 1'b1 || bus.acc_rd !== acc_m[1]) begin
            errors++;
            $display("FAIL single_drain: clr=%b busy=%b acc_rd=%h expected 0000 1 %h",
                     bus.clr, bus.busy, bus.acc_rd, acc_m[1]);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_priority();
        int exp;
        req = 4'b1111;
        bus.ovf_req = req;
        for (int s = 0; s < 4; s++) begin
            exp = pick(req, RR_EN ? rr_m : 0);
            run_service(exp, 17'($urandom), $urandom_range(0, 2), 4'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            bus.acc_rd_idx = 2'(k);
            tick();
            checks++;
            if (bus.acc_rd !== acc_m[k]) begin
                errors++;
                $display("FAIL prio_acc%0d: acc_rd=%h expected %h", k, bus.acc_rd, acc_m[k]);
            end
        end
    endtask

    task automatic test_collision();
        bus.acc_clr = 1'b1;
        bus.acc_rd_idx = 2'd0;
        tick();
        bus.acc_clr = 1'b0;
        acc_m[0] = '0;
        req = 4'b0001;
        bus.ovf_req = req;
        run_service(0, 17'd100, 1, 4'b0, 1'b0);
        req = 4'b0001;
        bus.ovf_req = req;
        run_service(0, 17'd5, 0, 4'b0, 1'b1);
        bus.acc_rd_idx = 2'd0;
        tick();
        checks++;
        if (bus.acc_rd !== 36'd5 || bus.acc_rd !== acc_m[0]) begin
            errors++;
            $display("FAIL collision_acc: acc_rd=%0d expected 5", bus.acc_rd);
        end
    endtask

    task automatic test_timeout_wait();
        bit clr_seen;
        for (int run = 0; run < 2; run++) begin
            bus.err_clr = 1'b1;
            tick();
            bus.err_clr = (run == 1);
            req = 4'b1000;
            bus.ovf_req = req;
            tick();
            checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_sel !== 2'd3) begin
                errors++;
                $display("FAIL tmo_grant: rd_en=%b rd_sel=%0d expected 1 3", bus.rd_en, bus.rd_sel);
            end
            clr_seen = 1'b0;
            for (int i = 0; i < 63; i++) begin
                tick();
                if (bus.clr !== 4'b0) clr_seen = 1'b1;
            end
            checks++;
            if (bus.err !== 1'b0 || bus.rd_en !== 1'b1) begin
                errors++;
                $display("FAIL tmo_early: err=%b rd_en=%b expected 0 1", bus.err, bus.rd_en);
            end
            tick();
            if (bus.clr !== 4'b0) clr_seen = 1'b1;
            checks++;
            if (bus.err !== 1'b1 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait_run%0d: err=%b rd_en=%b busy=%b expected 1 0 0",
                         run, bus.err, bus.rd_en, bus.busy);
            end
            req = 4'b0;
            bus.ovf_req = req;
            rr_m = 0;
            bus.err_clr = 1'b0;
            tick();
            checks++;
            if (clr_seen || bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL tmo_sticky: clr_seen=%b err=%b busy=%b expected 0 1 0",
                         clr_seen, bus.err, bus.busy);
            end
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err=%b expected 0", bus.err);
        end
    endtask

    task automatic test_timeout_drain();
        int n;
        logic [16:0] val;
        val = 17'($urandom);
        req = 4'b0001;
        bus.ovf_req = req;
        n = 0;
        while (bus.rd_en !== 1'b1 && n < 8) begin tick(); n++; end
        bus.rd_valid = 1'b1;
        bus.rd_data  = val;
        tick();
        bus.rd_valid = 1'b0;
        n = 0;
        while (bus.clr === 4'b0 && n < 8) begin tick(); n++; end
        checks++;
        if (bus.clr !== 4'b0001) begin
            errors++;
            $display("FAIL drain_clr: clr=%b expected 0001", bus.clr);
        end
        acc_m[0] = acc_m[0] + 36'(val);
        rr_m = 1;
        repeat (64) tick();
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_early: err=%b busy=%b expected 0 1", bus.err, bus.busy);
        end
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_tmo: err=%b busy=%b expected 1 0", bus.err, bus.busy);
        end
        req = 4'b0;
        bus.ovf_req = req;
        bus.acc_rd_idx = 2'd0;
        tick();
        checks++;
        if (bus.acc_rd !== acc_m[0]) begin
            errors++;
            $display("FAIL drain_acc_kept: acc_rd=%h expected %h", bus.acc_rd, acc_m[0]);
        end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_random();
        int exp;
        int guard;
        int k;
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 3);
                bus.acc_clr = 1'b1;
                bus.acc_rd_idx = 2'(k);
                acc_m[k] = '0;
                tick();
                bus.acc_clr = 1'b0;
            end
            req = 4'($urandom_range(1, 15));
            bus.ovf_req = req;
            guard = 0;
            while (req != 4'b0 && guard < 16) begin
                exp = pick(req, RR_EN ? rr_m : 0);
                run_service(exp, 17'($urandom), $urandom_range(0, 3),
                            (guard < 4) ? 4'($urandom) : 4'b0, 1'b0);
                guard++;
            end
            for (int a = 0; a < 4; a++) begin
                bus.acc_rd_idx = 2'(a);
                tick();
                checks++;
                if (bus.acc_rd !== acc_m[a]) begin
                    errors++;
                    $display("FAIL rand_acc%0d round %0d: acc_rd=%h expected %h", a, r, bus.acc_rd, acc_m[a]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [16:0] wv [4];
        logic [17:0] wm;
        int n;
        wv[0] = 17'h1FFFF;
        wv[1] = 17'h1FFFF;
        wv[2] = 17'h00001;
        wv[3] = 17'h00003;
        wm = '0;
        bus_w.acc_rd_idx = 2'd2;
        for (int s = 0; s < 4; s++) begin
            bus_w.ovf_req = 4'b0100;
            n = 0;
            while (bus_w.rd_en !== 1'b1 && n < 8) begin tick(); n++; end
            bus_w.rd_valid = 1'b1;
            bus_w.rd_data  = wv[s];
            tick();
            bus_w.rd_valid = 1'b0;
            n = 0;
            while (bus_w.clr === 4'b0 && n < 8) begin tick(); n++; end
            bus_w.ovf_req = 4'b0;
            tick();
            tick();
            wm = wm + 18'(wv[s]);
            if (s >= 2) begin
                checks++;
                if (bus_w.acc_rd !== wm || bus_w.err !== 1'b0 || bus_w.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_step%0d: acc_rd=%h err=%b busy=%b expected %h 0 0",
                             s, bus_w.acc_rd, bus_w.err, bus_w.busy, wm);
                end
            end
        end
        checks++;
        if (bus_w.acc_rd !== 18'h2) begin
            errors++;
            $display("FAIL wrap_final: acc_rd=%h expected 2", bus_w.acc_rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        req = 4'b0010;
        bus.ovf_req = req;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        checks++;
        if ({bus.rd_en, bus.rd_sel, bus.clr, bus.busy, bus.cur_sel, bus.err} !== 11'b0 ||
            bus.acc_rd !== 36'b0) begin
            errors++;
            $display("FAIL rst_wait_outputs: rd_en=%b rd_sel=%0d clr=%b busy=%b cur_sel=%0d err=%b acc_rd=%h expected all 0",
                     bus.rd_en, bus.rd_sel, bus.clr, bus.busy, bus.cur_sel, bus.err, bus.acc_rd);
        end
        req = 4'b0;
        bus.ovf_req = req;
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) acc_m[k] = '0;
        rr_m = 0;
        for (int a = 0; a < 4; a++) begin
            bus.acc_rd_idx = 2'(a);
            tick();
            checks++;
            if (bus.acc_rd !== acc_m[a] || bus.clr !== 4'b0) begin
                errors++;
                $display("FAIL rst_wait_acc%0d: acc_rd=%h clr=%b expected %h 0000",
                         a, bus.acc_rd, bus.clr, acc_m[a]);
            end
        end
    endtask

    initial begin
        RESET          = 1'b1;
        req            = 4'b0;
        bus.ovf_req    = 4'b0;
        bus.rd_valid   = 1'b0;
        bus.rd_data    = '0;
        bus.acc_rd_idx = 2'd0;
        bus.acc_clr    = 1'b0;
        bus.err_clr    = 1'b0;
        bus_w.ovf_req    = 4'b0;
        bus_w.rd_valid   = 1'b0;
        bus_w.rd_data    = '0;
        bus_w.acc_rd_idx = 2'd0;
        bus_w.acc_clr    = 1'b0;
        bus_w.err_clr    = 1'b0;
        rr_m = 0;
        for (int k = 0; k < 4; k++) acc_m[k] = '0;

        test_reset();
        test_single();
        test_priority();
        test_collision();
        test_timeout_wait();
        test_timeout_drain();
        test_random();
        test_wrap();
        test_reset_mid_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
